// File: rtl/wb_arbiter.sv
// wb_arbiter: slot-gated Wishbone bus scheduler with sticky hold-timeout flag.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module wb_arbiter #(
  parameter int COUNT       = 2,
  parameter int MAX_HOLD    = 64,
  parameter int GRANT_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                   wb_clock_i,
  input  logic                   wb_reset_i,
  input  logic                   arb_slot_i,
  input  logic [COUNT-1:0]       wbc_cycle_i,
  output logic [GRANT_WIDTH-1:0] grant_o,
  output logic                   grant_valid_o,
  output logic [GRANT_WIDTH-1:0] last_grant_o,
  output logic                   hold_timeout_o,
  input  logic                   timeout_clear_i
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, OWNED} state_e;
  state_e                 state_q;
  logic [GRANT_WIDTH-1:0] grant_q, last_q, win_d;
  logic                   valid_q, timeout_q, hit_q;
  logic [HW-1:0]          hold_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
  // Bit k of rot_d is the requester k+1 places after the previous winner.
  logic [COUNT-1:0] rot_d;
  always_comb begin
    rot_d = COUNT'({wbc_cycle_i, wbc_cycle_i} >> (int'(last_q) + 1));
    win_d = '0;
    for (int k = COUNT - 1; k >= 0; k--)
      if (rot_d[k]) win_d = GRANT_WIDTH'((int'(last_q) + 1 + k) % COUNT);
  end
`else
  always_comb begin
    win_d = '0;
    for (int k = COUNT - 1; k >= 0; k--)
      if (wbc_cycle_i[k]) win_d = GRANT_WIDTH'(k);
  end
`endif
  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GRANT_WIDTH'(COUNT - 1);
      valid_q   <= 1'b0;
      hold_q    <= '0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // hit_q marks the single cycle the counter sits newly at MAX_HOLD
      hit_q     <= (state_q == OWNED) && (hold_q == HW'(MAX_HOLD - 1));
      timeout_q <= hit_q || (timeout_q && !timeout_clear_i);
      if (state_q == IDLE) begin
        if (arb_slot_i && |wbc_cycle_i) begin
          state_q <= OWNED;
          grant_q <= win_d;
          last_q  <= win_d;
          valid_q <= 1'b1;
          hold_q  <= '0;
        end
      end else begin
        if (hold_q != HW'(MAX_HOLD)) hold_q <= hold_q + 1'b1;
        if (!wbc_cycle_i[grant_q]) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      end
    end
  end
  assign grant_o        = grant_q;
  assign grant_valid_o  = valid_q;
  assign last_grant_o   = last_q;
  assign hold_timeout_o = timeout_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus for wb_arbiter (COUNT=2, MAX_HOLD=4) checked
// every cycle against a time-scheduled behavioural model plus literal expectations.
module tb_wb_arbiter;
  localparam int COUNT = 2;
  localparam int MAX_HOLD = 4;
  logic       clk = 1'b0, rst = 1'b1, slot = 1'b0, clr = 1'b0;
  logic [1:0] req = 2'b00;
  logic       grant, valid, last, tmo;
  int         checks = 0, fails = 0;
  bit         chk_en = 1'b0;
  int         m_grant, m_last, m_age, m_pend, edge_n;
  bit         m_valid, m_flag, nf;
  int         exp_g [4];
  logic [1:0] drop;

  wb_arbiter #(.COUNT(COUNT), .MAX_HOLD(MAX_HOLD)) dut (
    .wb_clock_i(clk), .wb_reset_i(rst), .arb_slot_i(slot), .wbc_cycle_i(req),
    .grant_o(grant), .grant_valid_o(valid), .last_grant_o(last),
    .hold_timeout_o(tmo), .timeout_clear_i(clr));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] r, input int lst);
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= COUNT; k++) if (r[(lst + k) % COUNT]) return (lst + k) % COUNT;
`else
    for (int k = 0; k < COUNT; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  // Model: ownership by requests/slots; flag scheduled by absolute edge number.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_grant = 0; m_last = COUNT - 1; m_flag = 0; m_pend = -1; m_age = 0; edge_n = 0;
    end else begin
      edge_n++;
      nf = (m_pend == edge_n) || (m_flag && !clr);
      if (!m_valid) begin
        if (slot && req != 2'b00) begin
          m_grant = pick(req, m_last); m_last = m_grant; m_valid = 1; m_age = 0;
        end
      end else begin
        if (m_age == MAX_HOLD - 1) m_pend = edge_n + 1;
        m_age++;
        if (!req[m_grant]) m_valid = 0;
      end
      m_flag = nf;
    end
    #1;
    if (chk_en) begin
      chk("model_grant", int'(grant), m_grant);
      chk("model_valid", int'(valid), int'(m_valid));
      chk("model_last", int'(last), m_last);
      chk("model_timeout", int'(tmo), int'(m_flag));
    end
  end

  task automatic cyc(input logic s, input logic [1:0] r, input logic c);
    slot = s; req = r; clr = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; slot = 1'b0; req = 2'b00; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_last", int'(last), 1);
    chk("reset_timeout", int'(tmo), 0);
    // single request, grant and release latency
    cyc(0, 2'b01, 0);
    chk("no_slot_valid", int'(valid), 0);
    cyc(1, 2'b01, 0);
    chk("req0_valid", int'(valid), 1);
    chk("req0_grant", int'(grant), 0);
    chk("req0_last", int'(last), 0);
    cyc(0, 2'b01, 0);
    cyc(0, 2'b00, 0);
    chk("release_valid", int'(valid), 0);
    // both requesting, slot every 4 cycles, 3 owned cycles each
    do_reset();
    for (int r = 0; r < 4; r++) begin
      drop = exp_g[r] == 0 ? 2'b10 : 2'b01;
      cyc(1, 2'b11, 0);
      chk("sched_grant", int'(grant), exp_g[r]);
      chk("sched_valid", int'(valid), 1);
      cyc(0, 2'b11, 0);
      cyc(0, 2'b11, 0);
      cyc(0, drop, 0);
      chk("sched_gap", int'(valid), 0);
    end
    // controller 1 owns; controller 0 ignored until release
    do_reset();
    cyc(1, 2'b10, 0);
    chk("own1_grant", int'(grant), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b11, 0);
      chk("own1_hold", int'(grant), 1);
    end
    cyc(1, 2'b11, 0);
    chk("own1_slot_ignored", int'(grant), 1);
    cyc(0, 2'b01, 0);
    chk("own1_released", int'(valid), 0);
    cyc(0, 2'b01, 0);
    chk("wait_slot", int'(valid), 0);
    cyc(1, 2'b01, 0);
    chk("req0_after", int'(grant), 0);
    chk("req0_after_valid", int'(valid), 1);
    cyc(0, 2'b00, 0);
    // hold timeout
    do_reset();
    cyc(1, 2'b01, 0);
    repeat (4) cyc(0, 2'b01, 0);
    chk("tmo_before", int'(tmo), 0);
    cyc(0, 2'b01, 0);
    chk("tmo_set", int'(tmo), 1);
    repeat (4) cyc(0, 2'b01, 0);
    cyc(0, 2'b00, 0);
    chk("tmo_rel_valid", int'(valid), 0);
    chk("tmo_sticky", int'(tmo), 1);
    cyc(0, 2'b00, 1);
    chk("tmo_cleared", int'(tmo), 0);
    // clear coincident with a new set
    cyc(1, 2'b01, 0);
    repeat (4) cyc(0, 2'b01, 0);
    chk("tmo2_before", int'(tmo), 0);
    cyc(0, 2'b01, 1);
    chk("tmo_set_wins", int'(tmo), 1);
    cyc(0, 2'b00, 0);
    // async reset while owned
    cyc(1, 2'b01, 0);
    chk("pre_rst_valid", int'(valid), 1);
    #2 rst = 1'b1;
    #2;
    chk("arst_valid", int'(valid), 0);
    chk("arst_timeout", int'(tmo), 0);
    chk("arst_last", int'(last), 1);
    chk("arst_grant", int'(grant), 0);
    @(negedge clk);
    rst = 1'b0; req = 2'b00;
    // request pulse without slot, then slot without requests
    cyc(0, 2'b01, 0);
    cyc(0, 2'b01, 0);
    chk("pulse_no_grant", int'(valid), 0);
    cyc(0, 2'b00, 0);
    cyc(1, 2'b00, 0);
    chk("empty_slot", int'(valid), 0);
    cyc(0, 2'b00, 0);
    chk("still_idle", int'(valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
